array_drain_unpack: RTL and testbench

//   Downstream of the PE array edge. Captures the accumulated words shifted out of the

---
 rtl/array_drain_unpack_pkg.sv | 21 ++
 rtl/array_drain_unpack_if.sv | 13 +
 rtl/array_drain_unpack_fifo.sv | 55 +++++
 rtl/array_drain_unpack.sv | 146 ++++++++++++++
 tb/tb_array_drain_unpack.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_drain_unpack_pkg.sv
// Shared constants, FSM state type and lane-count helper for the array drain path.
package drain_pkg;

  localparam int PE_OUT_W = 64;  // one word shifted out of the edge cell
  localparam int W88      = 24;  // lane width in 8x8 mode
  localparam int W18      = 16;  // lane width in 1x8 mode
  localparam int OUT_W    = 32;  // sign-extended output lane width
  localparam int LANES88  = 2;
  localparam int LANES18  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Number of lanes packed in one word for the given mode tag.
  function automatic logic [2:0] lane_count(input logic m);
    return m ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/array_drain_unpack_if.sv
// Lane stream from the drain unpacker to the requant/writeback stage.
interface array_drain_unpack_if;
  import drain_pkg::*;

  logic             o_valid;
  logic             o_ready;
  logic [OUT_W-1:0] o_data;
  logic             o_last;
  logic             o_mode;

  modport master (output o_valid, output o_data, output o_last, output o_mode, input o_ready);
  modport slave  (input o_valid, input o_data, input o_last, input o_mode, output o_ready);
endinterface

// File: rtl/array_drain_unpack_fifo.sv
// Word FIFO: array storage, registered read data updated on pop.
module drain_word_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_rd_data;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_rd_data;
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage write; no reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers, occupancy and the registered head read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end
endmodule

// File: rtl/array_drain_unpack.sv
// Captures edge-cell words, queues them and emits one sign-extended lane per cycle.
module array_drain_unpack
  import drain_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int HI_WM = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mode,
  input  logic                shift_en,
  input  logic [PE_OUT_W-1:0] shift_word,
  output logic                almost_full,
  output logic                overflow,
  input  logic                clr_ovf,
  array_drain_unpack_if.master drain
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e              r_state;
  state_e              w_state_next;
  logic [1:0]          r_lane_cnt;
  logic [1:0]          w_lane_cnt_next;
  logic                r_overflow;
  logic                r_almost_full;

  logic [PE_OUT_W:0]   w_fifo_rd_data;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CW-1:0]       w_fifo_count;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_done;
  logic                w_fire;
  logic                w_last;
  logic                w_holding;
  logic                w_full;
  logic [CW-1:0]       w_occ;
  logic [CW-1:0]       w_occ_next;
  logic [PE_OUT_W-1:0] w_word;
  logic                w_tag;
  logic [OUT_W-1:0]    w_lane;
  logic [OUT_W-1:0]    w_lane88 [LANES88];
  logic [OUT_W-1:0]    w_lane18 [LANES18];

  // The FIFO's registered read data is the holding register: {mode tag, word}.
  assign w_word    = w_fifo_rd_data[PE_OUT_W-1:0];
  assign w_tag     = w_fifo_rd_data[PE_OUT_W];
  assign w_holding = (r_state == EMIT);

  // Occupancy counts the word being emitted, so DEPTH words total are in flight
  // and a pop on the final lane only frees a slot at the following edge.
  assign w_occ      = w_fifo_count + CW'(w_holding);
  assign w_full     = (w_occ == CW'(DEPTH)) | w_fifo_full;
  assign w_push     = shift_en & ~w_full;
  assign w_drop     = shift_en & w_full;
  assign w_occ_next = w_occ + CW'(w_push) - CW'(w_done);

  drain_word_fifo #(
    .W     (PE_OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data ({mode, shift_word}),
    .i_pop       (w_pop),
    .o_rd_data   (w_fifo_rd_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Unpack candidates, each sign-extended from its own MSB.
  for (genvar gi = 0; gi < LANES88; gi++) begin : g_lane88
    assign w_lane88[gi] = {{(OUT_W-W88){w_word[gi*W88+W88-1]}}, w_word[gi*W88 +: W88]};
  end
  for (genvar gi = 0; gi < LANES18; gi++) begin : g_lane18
    assign w_lane18[gi] = {{(OUT_W-W18){w_word[gi*W18+W18-1]}}, w_word[gi*W18 +: W18]};
  end

  assign w_lane = w_tag ? w_lane18[r_lane_cnt] : w_lane88[r_lane_cnt[0]];
  assign w_last = ({1'b0, r_lane_cnt} == (lane_count(w_tag) - 3'd1));
  assign w_fire = w_holding & drain.o_ready;

  assign drain.o_valid = w_holding;
  assign drain.o_data  = w_holding ? w_lane : '0;
  assign drain.o_last  = w_holding & w_last;
  assign drain.o_mode  = w_holding & w_tag;
  assign almost_full   = r_almost_full;
  assign overflow      = r_overflow;

  // Next state: load from the FIFO when idle, step lanes on handshake, chain words.
  always_comb begin
    w_state_next    = r_state;
    w_lane_cnt_next = r_lane_cnt;
    w_pop           = 1'b0;
    w_done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop           = 1'b1;
          w_lane_cnt_next = '0;
          w_state_next    = EMIT;
        end
      end
      EMIT: begin
        if (w_fire) begin
          if (w_last) begin
            w_done          = 1'b1;
            w_lane_cnt_next = '0;
            if (!w_fifo_empty) w_pop = 1'b1;
            else               w_state_next = IDLE;
          end else begin
            w_lane_cnt_next = r_lane_cnt + 2'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state and lane counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_lane_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lane_cnt <= w_lane_cnt_next;
    end
  end

  // Sticky overflow (a new drop beats clear) and registered watermark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow    <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
      r_almost_full <= (w_occ_next >= CW'(HI_WM));
    end
  end
endmodule

// File: tb/tb_array_drain_unpack.sv
// Randomized self-checking bench for array_drain_unpack against a lane-list model.
module tb_array_drain_unpack;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode = 1'b0;
  logic        shift_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [63:0] shift_word = '0;
  logic        almost_full;
  logic        overflow;

  array_drain_unpack_if drain_if ();

  always #5 clk = ~clk;

  array_drain_unpack dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .shift_en    (shift_en),
    .shift_word  (shift_word),
    .almost_full (almost_full),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf),
    .drain       (drain_if)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data[$];
  logic        exp_last[$];
  logic        exp_mode[$];
  logic [31:0] obs_data[$];
  logic        obs_last[$];
  logic        obs_mode[$];
  int          stall_viol;
  int          cyc;
  int          first_c;
  int          last_c;

  // Model: lane k of a word as a signed integer, truncated to 32 bits.
  function automatic logic [31:0] ref_lane(input logic m, input logic [63:0] w, input int k);
    longint v;
    if (!m) begin
      v = longint'((w >> (24 * k)) & 64'hFF_FFFF);
      if (v >= 64'sd8388608) v = v - 64'sd16777216;
    end else begin
      v = longint'((w >> (16 * k)) & 64'hFFFF);
      if (v >= 64'sd32768) v = v - 64'sd65536;
    end
    return v[31:0];
  endfunction

  // Model: append every lane a word should produce to the expected stream.
  function automatic void model_word(input logic m, input logic [63:0] w);
    int n;
    n = m ? 4 : 2;
    for (int k = 0; k < n; k++) begin
      exp_data.push_back(ref_lane(m, w, k));
      exp_last.push_back(k == n - 1);
      exp_mode.push_back(m);
    end
  endfunction

  function automatic logic [63:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic clear_queues();
    exp_data.delete(); exp_last.delete(); exp_mode.delete();
    obs_data.delete(); obs_last.delete(); obs_mode.delete();
    first_c = -1;
    last_c  = -1;
  endtask

  task automatic push_word(input logic m, input logic [63:0] w);
    @(negedge clk);
    mode       = m;
    shift_en   = 1'b1;
    shift_word = w;
    @(negedge clk);
    shift_en   = 1'b0;
  endtask

  // Gather up to n handshaken lanes within a cycle budget; tracks stall stability.
  task automatic collect(input int n, input int ready_pct, input int budget);
    logic [31:0] prev_data;
    logic        prev_stall;
    prev_data  = '0;
    prev_stall = 1'b0;
    stall_viol = 0;
    cyc        = 0;
    for (int c = 0; c < budget && obs_data.size() < n; c++) begin
      @(negedge clk);
      cyc++;
      drain_if.o_ready = ($urandom_range(99) < ready_pct);
      if (drain_if.o_valid) begin
        if (prev_stall && drain_if.o_data !== prev_data) stall_viol++;
        if (drain_if.o_ready) begin
          obs_data.push_back(drain_if.o_data);
          obs_last.push_back(drain_if.o_last);
          obs_mode.push_back(drain_if.o_mode);
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          $display("  lane %0d: data=%08h last=%0b mode=%0b", obs_data.size() - 1,
                   drain_if.o_data, drain_if.o_last, drain_if.o_mode);
        end
        prev_stall = ~drain_if.o_ready;
        prev_data  = drain_if.o_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
    @(negedge clk);
    drain_if.o_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drain_if.o_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({drain_if.o_valid, drain_if.o_last, drain_if.o_mode, almost_full, overflow, drain_if.o_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b last=%0b mode=%0b af=%0b ovf=%0b data=%08h, expected all 0",
               drain_if.o_valid, drain_if.o_last, drain_if.o_mode, almost_full, overflow, drain_if.o_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_mode0();
    clear_queues();
    push_word(1'b0, 64'h0000_800000_000005);
    model_word(1'b0, 64'h0000_800000_000005);
    collect(2, 100, 20);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL mode0_count: got %0d lanes, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_last[i], obs_mode[i]} !== {exp_data[i], exp_last[i], exp_mode[i]}) begin
        errors++;
        $display("FAIL mode0_lane%0d: got %08h/last=%0b/mode=%0b, expected %08h/last=%0b/mode=%0b",
                 i, obs_data[i], obs_last[i], obs_mode[i], exp_data[i], exp_last[i], exp_mode[i]);
      end
    end
    checks++;
    if (drain_if.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL mode0_idle: got o_valid=%0b, expected 0", drain_if.o_valid);
    end
  endtask

  task automatic test_mode1();
    clear_queues();
    push_word(1'b1, 64'hFFFF_7FFF_8000_0001);
    model_word(1'b1, 64'hFFFF_7FFF_8000_0001);
    collect(4, 100, 20);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL mode1_count: got %0d lanes, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_last[i], obs_mode[i]} !== {exp_data[i], exp_last[i], exp_mode[i]}) begin
        errors++;
        $display("FAIL mode1_lane%0d: got %08h/last=%0b/mode=%0b, expected %08h/last=%0b/mode=%0b",
                 i, obs_data[i], obs_last[i], obs_mode[i], exp_data[i], exp_last[i], exp_mode[i]);
      end
    end
  endtask

  task automatic test_watermark();
    logic [63:0] w;
    logic        exp_af;
    logic        exp_ovf;
    clear_queues();
    drain_if.o_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      w = rand_word();
      @(negedge clk);
      mode       = 1'b1;
      shift_en   = 1'b1;
      shift_word = w;
      clr_ovf    = (k == 18);
      if (k <= 16) model_word(1'b1, w);
      @(posedge clk);
      #1;
      exp_af  = (((k > 16) ? 16 : k) >= 12);
      exp_ovf = (k >= 17);
      $display("  push %0d: af=%0b ovf=%0b", k, almost_full, overflow);
      checks++;
      if (almost_full !== exp_af) begin
        errors++;
        $display("FAIL wm_almost_full_push%0d: got %0b, expected %0b", k, almost_full, exp_af);
      end
      checks++;
      if (overflow !== exp_ovf) begin
        errors++;
        $display("FAIL wm_overflow_push%0d: got %0b, expected %0b", k, overflow, exp_ovf);
      end
    end
    @(negedge clk);
    shift_en = 1'b0;
    clr_ovf  = 1'b0;
    mode     = 1'b0;
    collect(64, 100, 120);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL wm_count: got %0d lanes, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_last[i], obs_mode[i]} !== {exp_data[i], exp_last[i], exp_mode[i]}) begin
        errors++;
        $display("FAIL wm_lane%0d: got %08h/last=%0b/mode=%0b, expected %08h/last=%0b/mode=%0b",
                 i, obs_data[i], obs_last[i], obs_mode[i], exp_data[i], exp_last[i], exp_mode[i]);
      end
    end
    drain_if.o_ready = 1'b1;
    repeat (4) @(negedge clk);
    drain_if.o_ready = 1'b0;
    checks++;
    if ({drain_if.o_valid, almost_full, overflow} !== 3'b001) begin
      errors++;
      $display("FAIL wm_drained: got valid=%0b af=%0b ovf=%0b, expected valid=0 af=0 ovf=1",
               drain_if.o_valid, almost_full, overflow);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL wm_clr_ovf: got %0b, expected 0", overflow);
    end
  endtask

  task automatic test_random_stall();
    logic [63:0] w;
    clear_queues();
    drain_if.o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w = rand_word();
      push_word(1'b0, w);
      model_word(1'b0, w);
    end
    collect(6, 50, 300);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d lanes, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_last[i], obs_mode[i]} !== {exp_data[i], exp_last[i], exp_mode[i]}) begin
        errors++;
        $display("FAIL stall_lane%0d: got %08h/last=%0b/mode=%0b, expected %08h/last=%0b/mode=%0b",
                 i, obs_data[i], obs_last[i], obs_mode[i], exp_data[i], exp_last[i], exp_mode[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d data changes during stalls, expected 0", stall_viol);
    end
  endtask

  task automatic test_mode_switch();
    logic [63:0] wa;
    logic [63:0] wb;
    clear_queues();
    wa = rand_word();
    wb = rand_word();
    push_word(1'b0, wa);
    push_word(1'b1, wb);
    mode = 1'b0;
    model_word(1'b0, wa);
    model_word(1'b1, wb);
    collect(6, 100, 40);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL switch_count: got %0d lanes, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_last[i], obs_mode[i]} !== {exp_data[i], exp_last[i], exp_mode[i]}) begin
        errors++;
        $display("FAIL switch_lane%0d: got %08h/last=%0b/mode=%0b, expected %08h/last=%0b/mode=%0b",
                 i, obs_data[i], obs_last[i], obs_mode[i], exp_data[i], exp_last[i], exp_mode[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    logic        m;
    clear_queues();
    drain_if.o_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      w = rand_word();
      m = 1'($urandom_range(1));
      mode       = m;
      shift_en   = 1'b1;
      shift_word = w;
      model_word(m, w);
      @(negedge clk);
    end
    shift_en = 1'b0;
    collect(exp_data.size(), 100, 80);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d lanes, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_last[i], obs_mode[i]} !== {exp_data[i], exp_last[i], exp_mode[i]}) begin
        errors++;
        $display("FAIL b2b_lane%0d: got %08h/last=%0b/mode=%0b, expected %08h/last=%0b/mode=%0b",
                 i, obs_data[i], obs_last[i], obs_mode[i], exp_data[i], exp_last[i], exp_mode[i]);
      end
    end
    checks++;
    if (last_c - first_c + 1 != exp_data.size()) begin
      errors++;
      $display("FAIL b2b_no_bubble: got %0d cycles for lanes, expected %0d",
               last_c - first_c + 1, exp_data.size());
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    clear_queues();
    drain_if.o_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      mode       = 1'b0;
      shift_en   = 1'b1;
      shift_word = rand_word();
      @(negedge clk);
    end
    shift_en = 1'b0;
    checks++;
    if ({drain_if.o_valid, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre: got valid=%0b ovf=%0b, expected valid=1 ovf=1", drain_if.o_valid, overflow);
    end
    drain_if.o_ready = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({drain_if.o_valid, drain_if.o_last, drain_if.o_mode, almost_full, overflow, drain_if.o_data} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got valid=%0b last=%0b mode=%0b af=%0b ovf=%0b data=%08h, expected all 0",
               drain_if.o_valid, drain_if.o_last, drain_if.o_mode, almost_full, overflow, drain_if.o_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (drain_if.o_valid) stale++;
    end
    drain_if.o_ready = 1'b0;
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rstmid_stale: got %0d valid cycles after reset, expected 0", stale);
    end
    push_word(1'b1, 64'h0123_8765_4321_FEDC);
    model_word(1'b1, 64'h0123_8765_4321_FEDC);
    collect(4, 100, 20);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL rstmid_count: got %0d lanes, expected %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      checks++;
      if ({obs_data[i], obs_last[i], obs_mode[i]} !== {exp_data[i], exp_last[i], exp_mode[i]}) begin
        errors++;
        $display("FAIL rstmid_lane%0d: got %08h/last=%0b/mode=%0b, expected %08h/last=%0b/mode=%0b",
                 i, obs_data[i], obs_last[i], obs_mode[i], exp_data[i], exp_last[i], exp_mode[i]);
      end
    end
  endtask

  initial begin
    drain_if.o_ready = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_watermark();
    test_random_stall();
    test_mode_switch();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
